// File: rtl/pattern_serializer.sv
// Latches a WIDTH-bit pattern and replays it bit by bit on a registered output.
// Each bit is held for div+1 cycles, in either direction, one-shot or looping.
module pattern_serializer #(
  parameter int         WIDTH      = 8,
  parameter int         IDX_W      = $clog2(WIDTH),
  parameter int         DIV_W      = 4,
  parameter logic       IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             start,
  input  logic             mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  input  logic             stop,
  output logic             out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [IDX_W-1:0] LAST_HI = IDX_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] pattern_q;
  logic [IDX_W-1:0] idx_q;
  logic [DIV_W-1:0] hold_q;
  logic [DIV_W-1:0] div_q;
  logic             mode_q;
  logic             dir_q;
  logic             out_q;
  logic             done_q;

  logic [WIDTH-1:0] launch_pat_d;
  logic [IDX_W-1:0] launch_idx_d;
  logic [IDX_W-1:0] wrap_idx_d;
  logic [IDX_W-1:0] idx_d;
  logic             last_bit_d;
  logic             hold_done_d;

  // A same-cycle load is forwarded so playback starts on the new pattern.
  always_comb begin
    launch_pat_d = load ? pattern_in : pattern_q;
    launch_idx_d = dir ? LAST_HI : '0;
    wrap_idx_d   = dir_q ? LAST_HI : '0;
    last_bit_d   = dir_q ? (idx_q == '0) : (idx_q == LAST_HI);
    hold_done_d  = (hold_q == div_q);
    if (last_bit_d) begin
      idx_d = wrap_idx_d;
    end else begin
      idx_d = dir_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      div_q     <= '0;
      mode_q    <= 1'b0;
      dir_q     <= 1'b0;
      out_q     <= IDLE_LEVEL;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) pattern_q <= pattern_in;
          if (start) begin
            state_q <= RUN;
            mode_q  <= mode;
            dir_q   <= dir;
            div_q   <= div;
            hold_q  <= '0;
            idx_q   <= launch_idx_d;
            out_q   <= launch_pat_d[launch_idx_d];
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            out_q   <= IDLE_LEVEL;
          end else if (!hold_done_d) begin
            hold_q <= hold_q + DIV_W'(1);
          end else if (last_bit_d && !mode_q) begin
            state_q <= IDLE;
            out_q   <= IDLE_LEVEL;
            hold_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            hold_q <= '0;
            idx_q  <= idx_d;
            out_q  <= pattern_q[idx_d];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed and randomised checks of pattern_serializer against a model that
// derives the waveform from elapsed time since start.
module tb_pattern_serializer;

  localparam int W  = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset, load, start, mode, dir, stop;
  logic [W-1:0]  pattern_in;
  logic [DW-1:0] div;
  logic          out, busy, done;

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(W), .DIV_W(DW), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in),
    .start(start), .mode(mode), .dir(dir), .div(div), .stop(stop),
    .out(out), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position in the run is elapsed cycles / (div+1).
  logic [W-1:0] m_pat;
  bit           m_busy, m_done, m_mode, m_dir;
  int           m_div, m_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_out();
    int pos;
    if (!m_busy) return 1'b0;
    pos = (m_t / (m_div + 1)) % W;
    return m_pat[m_dir ? (W - 1 - pos) : pos];
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_pat = '0; m_busy = 0; m_done = 0; m_t = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (load) m_pat = pattern_in;
      if (start) begin
        m_busy = 1; m_t = 0;
        m_mode = mode; m_dir = dir; m_div = int'(div);
      end
    end else begin
      m_done = 0;
      if (stop) begin
        m_busy = 0;
      end else begin
        m_t++;
        if (!m_mode && m_t == W * (m_div + 1)) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("out", 32'(out), 32'(model_out()));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    reset = 0; load = 0; start = 0; stop = 0;
    mode = 0; dir = 0; div = '0; pattern_in = '0;
  endtask

  task automatic launch(input bit md, input bit dr, input logic [DW-1:0] dv);
    start = 1; mode = md; dir = dr; div = dv;
    tick();
    start = 0; mode = 0; dir = 0; div = '0;
  endtask

  task automatic do_load(input logic [W-1:0] p);
    load = 1; pattern_in = p;
    tick();
    load = 0; pattern_in = '0;
  endtask

  // Collects one bit per cycle starting from the bit already on out.
  task automatic capture8(output logic [W-1:0] wave);
    wave[0] = out;
    for (int i = 1; i < W; i++) begin
      tick();
      wave[i] = out;
    end
  endtask

  logic [W-1:0] wave;

  initial begin
    idle_inputs();
    m_pat = '0; m_busy = 0; m_done = 0; m_mode = 0; m_dir = 0; m_div = 0; m_t = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    check("rst_out", 32'(out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // One-shot LSB first, one cycle per bit.
    do_load(8'b10111000);
    launch(0, 0, 4'd0);
    capture8(wave);
    check("t1_wave", 32'(wave), 32'(8'b10111000));
    tick();
    check("t1_done", 32'(done), 32'(1));
    check("t1_busy", 32'(busy), 32'(0));
    tick();
    check("t1_done_clr", 32'(done), 32'(0));

    // MSB first, two cycles per bit: exactly 16 busy cycles.
    launch(0, 1, 4'd1);
    for (int i = 1; i < 16; i++) tick();
    check("t2_busy_end", 32'(busy), 32'(1));
    tick();
    check("t2_done", 32'(done), 32'(1));
    tick();

    // Loop mode for 20 cycles, then stop.
    launch(1, 0, 4'd0);
    for (int i = 0; i < 20; i++) tick();
    stop = 1;
    tick();
    stop = 0;
    check("t3_stop_busy", 32'(busy), 32'(0));
    check("t3_stop_done", 32'(done), 32'(0));
    tick();

    // Load and start attempted mid-run are ignored.
    launch(0, 0, 4'd0);
    tick(); tick();
    load = 1; start = 1; pattern_in = 8'hFF;
    tick();
    load = 0; start = 0; pattern_in = '0;
    for (int i = 0; i < 6; i++) tick();
    tick(); tick();
    launch(0, 0, 4'd0);
    capture8(wave);
    check("t4_replay", 32'(wave), 32'(8'b10111000));
    tick(); tick();

    // Same-cycle load and start uses the new pattern.
    load = 1; pattern_in = 8'b00000001;
    launch(0, 0, 4'd0);
    load = 0; pattern_in = '0;
    check("t5_first", 32'(out), 32'(1));
    for (int i = 0; i < 9; i++) tick();

    // Reset mid-run aborts with no done, pattern cleared.
    launch(0, 0, 4'd2);
    tick(); tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    check("t6_busy", 32'(busy), 32'(0));
    check("t6_done", 32'(done), 32'(0));
    launch(0, 1, 4'd0);
    for (int i = 0; i < 9; i++) begin
      check("t6_zero", 32'(out), 32'(0));
      tick();
    end

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 149) == 0);
      load       = ($urandom_range(0, 7) == 0);
      pattern_in = W'($urandom);
      start      = ($urandom_range(0, 5) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      mode       = ($urandom_range(0, 3) == 0);
      dir        = 1'($urandom);
      div        = ($urandom_range(0, 9) == 0) ? DW'($urandom) : DW'($urandom_range(0, 2));
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Parametrised waveform generator: latches a WIDTH-bit pattern and replays it one bit at a time on a single output, with a programmable hold time per bit.
- Replaces the fixed 8:1 select tree that the waveform-generator datapath drove from an external select counter. Bit index, direction, hold divider and one-shot/loop sequencing are now internal.
- Sits between the pattern register file and the waveform output pin.

Parameters:
- WIDTH, 8, pattern length in bits; must be >= 2.
- IDX_W, $clog2(WIDTH), width of the internal bit-index counter.
- DIV_W, 4, width of the per-bit hold divider.
- IDLE_LEVEL, 1'b0, value of out whenever busy=0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture pattern_in into the pattern register; honoured only when busy=0.
- pattern_in  input  WIDTH  pattern to be serialised.
- start  input  1  begin playback; honoured only when busy=0.
- mode  input  1  sampled at start: 0 = one-shot, 1 = continuous loop.
- dir  input  1  sampled at start: 0 = LSB first, 1 = MSB first.
- div  input  DIV_W  sampled at start; each bit is held for div+1 cycles.
- stop  input  1  abort playback.
- out  output  1  registered serial waveform.
- busy  output  1  high while playback is active.
- done  output  1  one-cycle pulse at the end of a one-shot run.

Behaviour:
- Reset, synchronous, highest priority: pattern=0, idx=0, hold counter=0, latched mode/dir/div=0, out=IDLE_LEVEL, busy=0, done=0. Reset mid-playback aborts the run and no done pulse is produced.
- States:
  - IDLE (busy=0): out=IDLE_LEVEL.
  - RUN (busy=1): out=pattern[idx].
- Priority within IDLE: load and start may be asserted in the same cycle. The new pattern is loaded first and playback starts with the new pattern's first bit at the same edge.
- IDLE -> RUN on start at edge k:
  - At edge k: busy=1, mode/dir/div latched, idx = 0 (dir=0) or WIDTH-1 (dir=1), out = pattern[first idx], hold counter=0.
  - Latency from start sampled to first bit on out: 1 edge, the same edge.
- Bit advance in RUN:
  - When hold counter == latched div: counter clears, idx moves by +1 (dir=0) or -1 (dir=1), out updates on that edge.
  - Otherwise the hold counter increments and out holds its value.
- Last bit (idx = WIDTH-1 for dir=0, 0 for dir=1) with hold expired:
  - mode=1: idx wraps to the first index and playback continues without a gap; busy stays 1 and done is not asserted.
  - mode=0: -> IDLE. busy=0, out=IDLE_LEVEL, done=1 for exactly that one cycle.
- One-shot busy duration: exactly WIDTH*(div+1) cycles.
- stop while busy: -> IDLE at the next edge. busy=0, out=IDLE_LEVEL, done=0. stop takes priority over bit advance and over end-of-run handling. stop while idle has no effect.
- Ignored while busy: load (pattern register unchanged), start, and changes to mode/dir/div.
- done is asserted only on a natural one-shot end, never in loop mode, and never on stop or reset.
- div=0 means one cycle per bit; the maximum hold is 2^DIV_W cycles per bit.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then load 8'b10111000 and start with mode=0, dir=0, div=0 -> out over 8 cycles = 0,0,0,1,1,1,0,1; busy high for exactly 8 cycles; done=1 in the 9th cycle only; out=0 afterwards.
- Same pattern, dir=1, div=1 -> out = 1,1,0,0,1,1,1,1,1,1,0,0,0,0,0,0 over 16 cycles; busy high for 16 cycles; single done pulse.
- Same pattern, mode=1, dir=0, div=0, run 20 cycles -> out repeats 00011101 with no idle gap at the wrap; done stays 0; then stop -> busy=0 and out=0 on the next edge, done=0.
- During a one-shot run, assert load with 8'hFF and start at cycle 3 -> waveform unchanged (00011101). After done, start again -> replays 8'b10111000, confirming the pattern was not overwritten.
- load=1 and start=1 in the same idle cycle with pattern_in=8'b00000001, dir=0 -> first out bit is 1, then seven 0s.
- Assert reset at cycle 4 of a div=2 run -> next edge: busy=0, out=0, done=0, idx=0; a subsequent start plays the all-zero pattern.
